// File: rtl/bp_cacc_vdp_mac.sv
// bp_cacc_vdp_mac: pipelined multiply-accumulate for vector dot products, one pair per cycle.
// Optional sticky overflow flag ovf_o built when BP_CACC_VDP_MAC_OVF_EN is defined.
module bp_cacc_vdp_mac #(
    parameter int width_p     = 64,
    parameter int cnt_width_p = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     a_i,
    input  logic [width_p-1:0]     b_i,
    input  logic                   last_i,
    input  logic                   v_i,
    output logic                   ready_o,
    output logic [width_p-1:0]     res_o,
    output logic [cnt_width_p-1:0] cnt_o,
    output logic                   res_v_o,
    input  logic                   res_yumi_i,
    output logic                   busy_o
`ifdef BP_CACC_VDP_MAC_OVF_EN
   ,output logic                   ovf_o
`endif
);
    typedef enum logic [1:0] {ACCUM, DRAIN, RESULT} state_e;
    state_e r_state, w_state_n;
    logic w_accept;
    logic [width_p-1:0] w_prod, w_sum, r_prod, r_acc, r_res;
    logic [cnt_width_p-1:0] w_cnt_inc, r_cnt, r_cnt_res;
    logic r_vm, r_last, r_res_v;
    assign ready_o   = r_state == ACCUM;
    assign w_accept  = v_i & ready_o;
    assign w_cnt_inc = &r_cnt ? r_cnt : r_cnt + 1'b1;
    assign res_o     = r_res;
    assign cnt_o     = r_cnt_res;
    assign res_v_o   = r_res_v;
    assign busy_o    = r_vm | (r_state != ACCUM) | (|r_cnt);
`ifdef BP_CACC_VDP_MAC_OVF_EN
    logic [2*width_p-1:0] w_full;
    logic w_carry, r_hi, r_ovf;
    assign w_full           = {{width_p{1'b0}}, a_i} * {{width_p{1'b0}}, b_i};
    assign w_prod           = w_full[width_p-1:0];
    assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_prod};
    assign ovf_o            = r_ovf & r_res_v;
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_hi  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_hi  <= w_accept & (|w_full[2*width_p-1:width_p]);
            if (r_res_v & res_yumi_i)
                r_ovf <= 1'b0;
            else if (r_vm & (r_hi | w_carry))
                r_ovf <= 1'b1;
        end
    end
`else
    assign w_prod = a_i * b_i;
    assign w_sum  = r_acc + r_prod;
`endif
    always_comb begin
        w_state_n = r_state;
        if (w_accept && last_i)
            w_state_n = DRAIN;
        else if (r_state == DRAIN && r_vm && r_last)
            w_state_n = RESULT;
        else if (r_state == RESULT && res_yumi_i)
            w_state_n = ACCUM;
    end
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= ACCUM;
            r_prod    <= '0;
            r_vm      <= 1'b0;
            r_last    <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_res     <= '0;
            r_cnt_res <= '0;
            r_res_v   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_prod  <= w_prod;
            r_vm    <= w_accept;
            r_last  <= w_accept & last_i;
            // the final pair closes the vector: publish the sum and restart from zero
            if (r_vm && r_last) begin
                r_res     <= w_sum;
                r_cnt_res <= w_cnt_inc;
                r_acc     <= '0;
                r_cnt     <= '0;
                r_res_v   <= 1'b1;
            end else if (r_vm) begin
                r_acc <= w_sum;
                r_cnt <= w_cnt_inc;
            end
            if (r_state == RESULT && res_yumi_i)
                r_res_v <= 1'b0;
        end
    end
endmodule
